// File: rtl/vga_text_ctrl.sv
// vga_text_ctrl: 640x480@60 raster sequencer for the text-mode glyph renderer.
// S0 raster/cell counters, S1 text-RAM address, S2 cell-pixel coordinates
// aligned with RAM read data, S3 sync/enable aligned with the renderer's
// output register. A two-state arbiter lets a host write the single-port
// text RAM whenever the raster is outside the text area.
// Optional feature macro: CURSOR_CTRL_EN (blinking underline cursor).
//
// Handshake: wr_req is a level request qualified with wr_addr/wr_data; the
// request is taken on a cycle where S0 is outside the text area and wr_ack
// pulses for exactly one cycle (the GRANT cycle). The host must keep
// wr_addr/wr_data stable until it sees wr_ack. An address beyond the text
// RAM is acknowledged without a write so the host never stalls.
`timescale 1ns/1ps
module vga_text_ctrl #(
  parameter int H_VIS  = 640,
  parameter int H_FP   = 16,
  parameter int H_SYNC = 96,
  parameter int H_BP   = 48,
  parameter int V_VIS  = 480,
  parameter int V_FP   = 10,
  parameter int V_SYNC = 2,
  parameter int V_BP   = 33,
  parameter int COLS   = 70,
  parameter int ROWS   = 30
) (
  input  logic        pclk,
  input  logic        rst,
`ifdef CURSOR_CTRL_EN
  input  logic [6:0]  cur_col,
  input  logic [4:0]  cur_row,
  output logic        cursor_px,
`endif
  output logic [11:0] ram_addr,
  output logic        ram_we,
  output logic [7:0]  ram_wdata,
  output logic [4:0]  x_9,
  output logic [4:0]  y_16,
  output logic        hsync,
  output logic        vsync,
  output logic        de,
  input  logic        wr_req,
  input  logic [11:0] wr_addr,
  input  logic [7:0]  wr_data,
  output logic        wr_ack
);

  localparam logic [9:0]  H_MAX   = 10'(H_VIS + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0]  V_MAX   = 10'(V_VIS + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0]  H_TXT   = 10'(COLS * 9);
  localparam logic [9:0]  V_TXT   = 10'(ROWS * 16);
  localparam logic [9:0]  HS_BEG  = 10'(H_VIS + H_FP);
  localparam logic [9:0]  HS_END  = 10'(H_VIS + H_FP + H_SYNC - 1);
  localparam logic [9:0]  VS_BEG  = 10'(V_VIS + V_FP);
  localparam logic [9:0]  VS_END  = 10'(V_VIS + V_FP + V_SYNC - 1);
  localparam logic [6:0]  COL_MAX = 7'(COLS - 1);
  localparam logic [4:0]  ROW_MAX = 5'(ROWS - 1);
  localparam logic [11:0] COLS_W  = 12'(COLS);
  localparam logic [11:0] CELLS   = 12'(COLS * ROWS);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_GRANT = 1'b1;

  logic [9:0]  r_h, r_v;
  logic [3:0]  r_xs, r_ys;
  logic [6:0]  r_col;
  logic [4:0]  r_row;
  logic [0:0]  r_state;
  logic [11:0] r_ram_addr;
  logic        r_ram_we, r_wr_ack;
  logic [7:0]  r_ram_wdata;
  logic [3:0]  r_xs_d1, r_ys_d1, r_x9, r_y16;
  logic [2:0]  r_hs_sr, r_vs_sr, r_de_sr;

  logic        w_h_wrap, w_v_wrap, w_text, w_hs, w_vs;
  logic [11:0] w_cell_addr;

  assign w_h_wrap    = (r_h == H_MAX);
  assign w_v_wrap    = w_h_wrap && (r_v == V_MAX);
  assign w_text      = (r_h < H_TXT) && (r_v < V_TXT);
  assign w_hs        = !((r_h >= HS_BEG) && (r_h <= HS_END));
  assign w_vs        = !((r_v >= VS_BEG) && (r_v <= VS_END));
  assign w_cell_addr = 12'(r_row) * COLS_W + 12'(r_col);

  // S0: pixel and line counters of the full raster
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      r_h <= '0;
      r_v <= '0;
    end else begin
      r_h <= w_h_wrap ? '0 : r_h + 10'd1;
      if (w_h_wrap) r_v <= (r_v == V_MAX) ? '0 : r_v + 10'd1;
    end
  end

  // S0: horizontal cell position, advancing only across the text columns
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      r_xs  <= '0;
      r_col <= '0;
    end else if (w_h_wrap) begin
      r_xs  <= '0;
      r_col <= '0;
    end else if (r_h < H_TXT) begin
      if (r_xs == 4'd8) begin
        r_xs  <= '0;
        r_col <= (r_col == COL_MAX) ? '0 : r_col + 7'd1;
      end else begin
        r_xs <= r_xs + 4'd1;
      end
    end
  end

  // S0: vertical cell position, advancing on each text line wrap
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      r_ys  <= '0;
      r_row <= '0;
    end else if (w_v_wrap) begin
      r_ys  <= '0;
      r_row <= '0;
    end else if (w_h_wrap && (r_v < V_TXT)) begin
      r_ys <= r_ys + 4'd1;
      if (r_ys == 4'd15) r_row <= (r_row == ROW_MAX) ? '0 : r_row + 5'd1;
    end
  end

  // S1 + arbiter: display fetch owns the RAM in the text area, host otherwise.
  // Out-of-range host addresses still pass through GRANT but with ram_we low.
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_ram_addr  <= '0;
      r_ram_we    <= 1'b0;
      r_ram_wdata <= '0;
      r_wr_ack    <= 1'b0;
    end else begin
      r_ram_we <= 1'b0;
      r_wr_ack <= 1'b0;
      if (w_text) begin
        r_state    <= ST_IDLE;
        r_ram_addr <= w_cell_addr;
      end else if ((r_state == ST_IDLE) && wr_req) begin
        r_state     <= ST_GRANT;
        r_ram_addr  <= wr_addr;
        r_ram_we    <= (wr_addr < CELLS);
        r_ram_wdata <= wr_data;
        r_wr_ack    <= 1'b1;
      end else begin
        r_state <= ST_IDLE;
      end
    end
  end

  // S2: cell-pixel coordinates delayed to meet the RAM read data
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      r_xs_d1 <= '0;
      r_ys_d1 <= '0;
      r_x9    <= '0;
      r_y16   <= '0;
    end else begin
      r_xs_d1 <= r_xs;
      r_ys_d1 <= r_ys;
      r_x9    <= r_xs_d1;
      r_y16   <= r_ys_d1;
    end
  end

  // S3: sync and display enable delayed three cycles
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      r_hs_sr <= 3'b111;
      r_vs_sr <= 3'b111;
      r_de_sr <= 3'b000;
    end else begin
      r_hs_sr <= {r_hs_sr[1:0], w_hs};
      r_vs_sr <= {r_vs_sr[1:0], w_vs};
      r_de_sr <= {r_de_sr[1:0], w_text};
    end
  end

`ifdef CURSOR_CTRL_EN
  logic [5:0] r_frame;
  logic [2:0] r_cur_sr;
  logic       w_cur;

  assign w_cur = r_frame[5] && w_text && (r_col == cur_col) &&
                 (r_row == cur_row) && (r_ys >= 4'd14);

  // Frame counter steps on the line wrap that starts vsync; S3-aligned underline
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      r_frame  <= '0;
      r_cur_sr <= '0;
    end else begin
      if (w_h_wrap && (r_v == VS_BEG - 10'd1)) r_frame <= r_frame + 6'd1;
      r_cur_sr <= {r_cur_sr[1:0], w_cur};
    end
  end

  assign cursor_px = r_cur_sr[2];
`endif

  assign ram_addr  = r_ram_addr;
  assign ram_we    = r_ram_we;
  assign ram_wdata = r_ram_wdata;
  assign wr_ack    = r_wr_ack;
  assign x_9       = {1'b0, r_x9};
  assign y_16      = {1'b0, r_y16};
  assign hsync     = r_hs_sr[2];
  assign vsync     = r_vs_sr[2];
  assign de        = r_de_sr[2];

endmodule

// File: tb/tb_vga_text_ctrl.sv
// tb_vga_text_ctrl: directed bench for vga_text_ctrl. A full-size instance
// covers addressing, arbitration and line timing; a reduced-timing instance
// covers complete-frame sync behaviour (and the cursor when CURSOR_CTRL_EN).
`timescale 1ns/1ps
module tb_vga_text_ctrl;

  logic        pclk = 1'b0;
  logic        rst  = 1'b1;
  logic        wr_req = 1'b0;
  logic [11:0] wr_addr = '0;
  logic [7:0]  wr_data = '0;
  logic [11:0] ram_addr;
  logic        ram_we, wr_ack, hsync, vsync, de;
  logic [7:0]  ram_wdata;
  logic [4:0]  x_9, y_16;

  logic        s_wr_req = 1'b0;
  logic [11:0] s_wr_addr = '0;
  logic [7:0]  s_wr_data = '0;
  logic [11:0] s_ram_addr;
  logic        s_ram_we, s_wr_ack, s_hsync, s_vsync, s_de;
  logic [7:0]  s_ram_wdata;
  logic [4:0]  s_x_9, s_y_16;

`ifdef CURSOR_CTRL_EN
  logic [6:0] cur_col = 7'd0, s_cur_col = 7'd1;
  logic [4:0] cur_row = 5'd0, s_cur_row = 5'd0;
  logic       cursor_px, s_cursor_px;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  int cyc;

  logic [7:0] mem [0:4095];
  logic [7:0] ascii_read;
  bit         mem_ready = 1'b0;

  // clock / reset
  always #5 pclk = ~pclk;

  always @(posedge pclk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  // text RAM model: preloaded with the low byte of each address, 1-cycle read
  always @(posedge pclk) begin
    if (!mem_ready) begin
      for (int i = 0; i < 4096; i++) mem[i] <= i[7:0];
      mem_ready <= 1'b1;
    end else begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      ascii_read <= mem[ram_addr];
    end
  end

  vga_text_ctrl u_dut (
    .pclk(pclk), .rst(rst),
`ifdef CURSOR_CTRL_EN
    .cur_col(cur_col), .cur_row(cur_row), .cursor_px(cursor_px),
`endif
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata),
    .x_9(x_9), .y_16(y_16), .hsync(hsync), .vsync(vsync), .de(de),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack)
  );

  // reduced raster: 28 px/line (text 18), 22 lines/frame (text 16)
  vga_text_ctrl #(
    .H_VIS(20), .H_FP(2), .H_SYNC(4), .H_BP(2),
    .V_VIS(16), .V_FP(2), .V_SYNC(2), .V_BP(2),
    .COLS(2), .ROWS(1)
  ) u_small (
    .pclk(pclk), .rst(rst),
`ifdef CURSOR_CTRL_EN
    .cur_col(s_cur_col), .cur_row(s_cur_row), .cursor_px(s_cursor_px),
`endif
    .ram_addr(s_ram_addr), .ram_we(s_ram_we), .ram_wdata(s_ram_wdata),
    .x_9(s_x_9), .y_16(s_y_16), .hsync(s_hsync), .vsync(s_vsync), .de(s_de),
    .wr_req(s_wr_req), .wr_addr(s_wr_addr), .wr_data(s_wr_data), .wr_ack(s_wr_ack)
  );

  // driver tasks
  task automatic goto(input int t);
    while (cyc < t) begin
      @(posedge pclk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) @(posedge pclk);
    @(negedge pclk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge pclk);
    #1;
    n_tests++; if (ram_addr !== 12'd0) begin n_fail++; $display("FAIL reset_ram_addr: got %0d expected 0", ram_addr); end
    n_tests++; if (ram_we !== 1'b0) begin n_fail++; $display("FAIL reset_ram_we: got %b expected 0", ram_we); end
    n_tests++; if (wr_ack !== 1'b0) begin n_fail++; $display("FAIL reset_wr_ack: got %b expected 0", wr_ack); end
    n_tests++; if (x_9 !== 5'd0 || y_16 !== 5'd0) begin n_fail++; $display("FAIL reset_xy: got x_9=%0d y_16=%0d expected 0 0", x_9, y_16); end
    n_tests++; if (hsync !== 1'b1 || vsync !== 1'b1) begin n_fail++; $display("FAIL reset_sync: got hs=%b vs=%b expected 1 1", hsync, vsync); end
    n_tests++; if (de !== 1'b0) begin n_fail++; $display("FAIL reset_de: got %b expected 0", de); end
    @(negedge pclk);
    rst = 1'b0;
  endtask

  // lines 0..2 of the full raster, cycle by cycle, with the 3-cycle S3 delay
  task automatic test_sync_de();
    int err_hs = 0, err_de = 0, err_vs = 0, first_hs = -1, first_de = -1;
    int hs_low1 = 0, de_hi1 = 0, hs_falls = 0;
    logic prev_hs = 1'b1;
    for (int n = 1; n <= 3 * 800 + 2; n++) begin
      int c, h, v;
      logic exp_hs, exp_de;
      goto(n);
      c = n - 3;
      h = (c < 0) ? 0 : c % 800;
      v = (c < 0) ? 0 : c / 800;
      exp_hs = (c < 0) ? 1'b1 : !(h >= 656 && h <= 751);
      exp_de = (c < 0) ? 1'b0 : (h < 630 && v < 480);
      if (hsync !== exp_hs) begin err_hs++; if (first_hs < 0) first_hs = n; end
      if (de !== exp_de) begin err_de++; if (first_de < 0) first_de = n; end
      if (vsync !== 1'b1) err_vs++;
      if (prev_hs === 1'b1 && hsync === 1'b0) hs_falls++;
      prev_hs = hsync;
      if (c >= 800 && c < 1600) begin
        if (hsync === 1'b0) hs_low1++;
        if (de === 1'b1) de_hi1++;
      end
    end
    n_tests++; if (err_hs !== 0) begin n_fail++; $display("FAIL sync_hs_wave: %0d bad cycles (first %0d) expected 0", err_hs, first_hs); end
    n_tests++; if (err_de !== 0) begin n_fail++; $display("FAIL sync_de_wave: %0d bad cycles (first %0d) expected 0", err_de, first_de); end
    n_tests++; if (err_vs !== 0) begin n_fail++; $display("FAIL sync_vs_top: %0d low cycles expected 0", err_vs); end
    n_tests++; if (hs_low1 !== 96) begin n_fail++; $display("FAIL hs_width: got %0d expected 96", hs_low1); end
    n_tests++; if (de_hi1 !== 630) begin n_fail++; $display("FAIL de_per_line: got %0d expected 630", de_hi1); end
    n_tests++; if (hs_falls !== 3) begin n_fail++; $display("FAIL hs_pulses: got %0d expected 3", hs_falls); end
  endtask

  // write requested at S0 (v=10,h=100): taken at S0 h=630, ack seen one cycle later
  task automatic test_host_write();
    int ack_at = -1, we_cnt = 0, ack_cnt = 0, bad_we = 0;
    logic [11:0] g_addr = '0;
    logic [7:0]  g_data = '0;
    logic        g_we = 1'b0;
    goto(10 * 800 + 100);
    wr_req = 1'b1; wr_addr = 12'h005; wr_data = 8'h41;
    for (int n = 10 * 800 + 101; n <= 10 * 800 + 700; n++) begin
      int c;
      goto(n);
      c = n - 1;
      if (ram_we === 1'b1) begin
        we_cnt++;
        if ((c % 800) < 630 && (c / 800) < 480) bad_we++;
      end
      if (wr_ack === 1'b1) begin
        ack_cnt++;
        if (ack_at < 0) begin
          ack_at = n; g_addr = ram_addr; g_data = ram_wdata; g_we = ram_we;
          wr_req = 1'b0;
        end
      end
    end
    n_tests++; if (ack_at !== 8631) begin n_fail++; $display("FAIL wr_ack_cycle: got %0d expected 8631", ack_at); end
    n_tests++; if (g_addr !== 12'h005 || g_data !== 8'h41 || g_we !== 1'b1) begin n_fail++; $display("FAIL wr_grant_bus: got addr=%0h data=%0h we=%b expected 5 41 1", g_addr, g_data, g_we); end
    n_tests++; if (we_cnt !== 1 || ack_cnt !== 1) begin n_fail++; $display("FAIL wr_pulses: got we=%0d ack=%0d expected 1 1", we_cnt, ack_cnt); end
    n_tests++; if (bad_we !== 0) begin n_fail++; $display("FAIL wr_in_text: got %0d expected 0", bad_we); end
    n_tests++; if (mem[5] !== 8'h41) begin n_fail++; $display("FAIL wr_mem: got %0h expected 41", mem[5]); end
  endtask

  // out-of-range address held across two acks: acks at 10231 and 10233, no write
  task automatic test_out_of_range();
    int ack1 = -1, ack2 = -1, ack_cnt = 0, we_cnt = 0;
    goto(12 * 800 + 100);
    wr_req = 1'b1; wr_addr = 12'd2100; wr_data = 8'h55;
    for (int n = 12 * 800 + 101; n <= 12 * 800 + 700; n++) begin
      goto(n);
      if (ram_we === 1'b1) we_cnt++;
      if (wr_ack === 1'b1) begin
        ack_cnt++;
        if (ack_cnt == 1) ack1 = n;
        if (ack_cnt == 2) begin ack2 = n; wr_req = 1'b0; end
      end
    end
    n_tests++; if (ack1 !== 10231) begin n_fail++; $display("FAIL oor_ack1: got %0d expected 10231", ack1); end
    n_tests++; if (ack2 !== 10233 || ack_cnt !== 2) begin n_fail++; $display("FAIL oor_back_to_back: got ack2=%0d count=%0d expected 10233 2", ack2, ack_cnt); end
    n_tests++; if (we_cnt !== 0) begin n_fail++; $display("FAIL oor_we: got %0d expected 0", we_cnt); end
    n_tests++; if (mem[2100] !== 8'h34) begin n_fail++; $display("FAIL oor_mem: got %0h expected 34", mem[2100]); end
  endtask

  // line 37 = row 2, ys 5; cell col 3 spans h 27..35; last cell col 69 at h 621..629
  task automatic test_fetch();
    int base = 37 * 800;
    goto(base + 27 + 1);
    n_tests++; if (ram_addr !== 12'd143) begin n_fail++; $display("FAIL fetch_addr: got %0d expected 143", ram_addr); end
    for (int k = 0; k < 9; k++) begin
      goto(base + 27 + k + 2);
      n_tests++; if (ascii_read !== 8'h8F) begin n_fail++; $display("FAIL fetch_ascii_k%0d: got %0h expected 8f", k, ascii_read); end
      n_tests++; if (x_9 !== 5'(k)) begin n_fail++; $display("FAIL fetch_x9_k%0d: got %0d expected %0d", k, x_9, k); end
      n_tests++; if (y_16 !== 5'd5) begin n_fail++; $display("FAIL fetch_y16_k%0d: got %0d expected 5", k, y_16); end
    end
    goto(base + 629 + 2);
    n_tests++; if (ascii_read !== 8'hD1 || x_9 !== 5'd8) begin n_fail++; $display("FAIL fetch_last_cell: got ascii=%0h x_9=%0d expected d1 8", ascii_read, x_9); end
  endtask

  // reset asserted in the GRANT cycle: no write, outputs back to reset values
  task automatic test_reset_grant();
    int ack_at = -1;
    logic we_at = 1'b0;
    goto(40 * 800 + 100);
    wr_req = 1'b1; wr_addr = 12'd7; wr_data = 8'h99;
    for (int n = 40 * 800 + 101; n <= 40 * 800 + 700; n++) begin
      goto(n);
      if (wr_ack === 1'b1) begin ack_at = n; we_at = ram_we; rst = 1'b1; break; end
    end
    #1;
    n_tests++; if (ack_at !== 32631 || we_at !== 1'b1) begin n_fail++; $display("FAIL rg_grant: got ack=%0d we=%b expected 32631 1", ack_at, we_at); end
    n_tests++; if (ram_we !== 1'b0 || wr_ack !== 1'b0) begin n_fail++; $display("FAIL rg_abort: got we=%b ack=%b expected 0 0", ram_we, wr_ack); end
    n_tests++; if (hsync !== 1'b1 || vsync !== 1'b1 || de !== 1'b0) begin n_fail++; $display("FAIL rg_sync: got hs=%b vs=%b de=%b expected 1 1 0", hsync, vsync, de); end
    wr_req = 1'b0;
    repeat (2) @(posedge pclk);
    #1;
    n_tests++; if (mem[7] !== 8'h07) begin n_fail++; $display("FAIL rg_mem: got %0h expected 07", mem[7]); end
  endtask

  // reduced raster, one whole frame of 616 cycles seen through the S3 delay
  task automatic test_small_frame();
    int vs_low = 0, vs_falls = 0, hs_low = 0, hs_falls = 0, de_hi = 0, cur_hi = 0;
    logic prev_hs = 1'b1, prev_vs = 1'b1;
    for (int n = 3; n < 3 + 616; n++) begin
      goto(n);
      if (s_vsync === 1'b0) vs_low++;
      if (s_hsync === 1'b0) hs_low++;
      if (s_de === 1'b1) de_hi++;
      if (prev_vs === 1'b1 && s_vsync === 1'b0) vs_falls++;
      if (prev_hs === 1'b1 && s_hsync === 1'b0) hs_falls++;
      prev_vs = s_vsync;
      prev_hs = s_hsync;
`ifdef CURSOR_CTRL_EN
      if (s_cursor_px === 1'b1) cur_hi++;
`endif
    end
    n_tests++; if (vs_low !== 56 || vs_falls !== 1) begin n_fail++; $display("FAIL frame_vsync: got low=%0d pulses=%0d expected 56 1", vs_low, vs_falls); end
    n_tests++; if (hs_low !== 88 || hs_falls !== 22) begin n_fail++; $display("FAIL frame_hsync: got low=%0d pulses=%0d expected 88 22", hs_low, hs_falls); end
    n_tests++; if (de_hi !== 288) begin n_fail++; $display("FAIL frame_de: got %0d expected 288", de_hi); end
`ifdef CURSOR_CTRL_EN
    n_tests++; if (cur_hi !== 0) begin n_fail++; $display("FAIL cursor_frame0: got %0d expected 0", cur_hi); end
`endif
  endtask

`ifdef CURSOR_CTRL_EN
  // frame 32: underline on lines 14-15, pixels 9..17 of the reduced raster
  task automatic test_cursor();
    int cur_hi = 0, bad_pos = 0;
    for (int n = 32 * 616 + 3; n < 33 * 616 + 3; n++) begin
      int c, h, v;
      goto(n);
      c = (n - 3) % 616;
      h = c % 28;
      v = c / 28;
      if (s_cursor_px === 1'b1) begin
        cur_hi++;
        if (!(v >= 14 && v <= 15 && h >= 9 && h <= 17)) bad_pos++;
      end
    end
    n_tests++; if (cur_hi !== 18 || bad_pos !== 0) begin n_fail++; $display("FAIL cursor_frame32: got count=%0d misplaced=%0d expected 18 0", cur_hi, bad_pos); end
  endtask
`endif

  initial begin
    test_reset();
    test_sync_de();
    test_host_write();
    test_out_of_range();
    test_fetch();
    test_reset_grant();
    do_reset();
    test_small_frame();
`ifdef CURSOR_CTRL_EN
    test_cursor();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
